cordic_vector_12b: RTL and testbench

CORDIC_VECTOR_12B -- requirements
Module: cordic_vector_12b

---
 rtl/cordic_vector_12b.sv | 180 ++++++++++++++++++
 tb/tb_cordic_vector_12b.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector_12b.sv
// Iterative CORDIC vectoring engine: (x, y) -> (angle, magnitude), one micro-rotation per clock.
// Define GAIN_COMP_EN to add a COMP state that divides out the CORDIC gain before the magnitude is saturated.
module cordic_vector_12b #(
    parameter int WIDTH = 12,
    parameter int ITER  = 12
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   angle,
    output logic [WIDTH:0]     mag
);

    localparam int XW = WIDTH + 3;
    localparam logic signed [XW-1:0] MAG_MAX = {2'b00, {(WIDTH+1){1'b1}}};

`ifdef GAIN_COMP_EN
    typedef enum logic [2:0] {IDLE, PRE, RUN, COMP, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, PRE, RUN, DONE} state_t;
`endif

    state_t                r_state;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic [WIDTH-1:0]      r_z;
    logic [4:0]            r_i;
    logic                  r_zero;
    logic                  r_inReady;
    logic                  r_outValid;
    logic [WIDTH-1:0]      r_angle;
    logic [WIDTH:0]        r_mag;

    logic signed [XW-1:0]  w_xShift;
    logic signed [XW-1:0]  w_yShift;
    logic signed [XW-1:0]  w_xNext;
    logic signed [XW-1:0]  w_yNext;
    logic [WIDTH-1:0]      w_zNext;
    logic [WIDTH-1:0]      w_atan;
    logic                  w_lastIter;

    // Arctangents held as 32-bit fractions of a full turn, rescaled to WIDTH bits with rounding.
    function automatic logic [WIDTH-1:0] atanLut(input logic [4:0] idx);
        logic [31:0] a32;
        case (idx)
            5'd0:    a32 = 32'h2000_0000;
            5'd1:    a32 = 32'h12E4_051E;
            5'd2:    a32 = 32'h09FB_385B;
            5'd3:    a32 = 32'h0511_11D4;
            5'd4:    a32 = 32'h028B_0D43;
            5'd5:    a32 = 32'h0145_D7E1;
            5'd6:    a32 = 32'h00A2_F61E;
            5'd7:    a32 = 32'h0051_7C55;
            5'd8:    a32 = 32'h0028_BE53;
            5'd9:    a32 = 32'h0014_5F2F;
            5'd10:   a32 = 32'h000A_2F98;
            5'd11:   a32 = 32'h0005_17CC;
            5'd12:   a32 = 32'h0002_8BE6;
            5'd13:   a32 = 32'h0001_45F3;
            5'd14:   a32 = 32'h0000_A2FA;
            5'd15:   a32 = 32'h0000_517D;
            default: a32 = 32'd683565276 >> idx;
        endcase
        return WIDTH'((({32'd0, a32} << WIDTH) + 64'h0000_0000_8000_0000) >> 32);
    endfunction

    // Negative values cannot occur after PRE folds the vector into the right half-plane; clamp anyway.
    function automatic logic [WIDTH:0] satMag(input logic signed [XW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > MAG_MAX)
            return {(WIDTH+1){1'b1}};
        else
            return v[WIDTH:0];
    endfunction

`ifdef GAIN_COMP_EN
    function automatic logic signed [XW-1:0] gainComp(input logic signed [XW-1:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction
`endif

    always_comb begin
        w_atan     = atanLut(r_i);
        w_xShift   = r_x >>> r_i;
        w_yShift   = r_y >>> r_i;
        w_lastIter = (r_i == 5'(ITER - 1));
        if (!r_y[XW-1]) begin
            w_xNext = r_x + w_yShift;
            w_yNext = r_y - w_xShift;
            w_zNext = r_z + w_atan;
        end else begin
            w_xNext = r_x - w_yShift;
            w_yNext = r_y + w_xShift;
            w_zNext = r_z - w_atan;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_i        <= '0;
            r_zero     <= 1'b0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_angle    <= '0;
            r_mag      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_inReady <= 1'b1;
                    if (in_valid && r_inReady) begin
                        r_x       <= {{3{x_in[WIDTH-1]}}, x_in};
                        r_y       <= {{3{y_in[WIDTH-1]}}, y_in};
                        r_zero    <= (x_in == '0) && (y_in == '0);
                        r_inReady <= 1'b0;
                        r_state   <= PRE;
                    end
                end
                PRE: begin
                    if (r_x[XW-1]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= {1'b1, {(WIDTH-1){1'b0}}};
                    end else begin
                        r_z <= '0;
                    end
                    r_i     <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_x <= w_xNext;
                    r_y <= w_yNext;
                    r_z <= w_zNext;
                    r_i <= r_i + 5'd1;
                    if (w_lastIter) begin
`ifdef GAIN_COMP_EN
                        r_state <= COMP;
`else
                        r_angle    <= r_zero ? '0 : w_zNext;
                        r_mag      <= r_zero ? '0 : satMag(w_xNext);
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
`endif
                    end
                end
`ifdef GAIN_COMP_EN
                COMP: begin
                    r_angle    <= r_zero ? '0 : r_z;
                    r_mag      <= r_zero ? '0 : satMag(gainComp(r_x));
                    r_outValid <= 1'b1;
                    r_state    <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign angle     = r_angle;
    assign mag       = r_mag;

endmodule

// File: tb/tb_cordic_vector_12b.sv
// Scoreboard bench for cordic_vector_12b: directed vectors queue expected results, a monitor checks them.
// Honours GAIN_COMP_EN the same way as the design (latency and magnitude expectations).
module tb_cordic_vector_12b;

    localparam int WIDTH = 12;
    localparam int NVEC  = 10;

    typedef struct {
        int expAngle;
        int angTol;
        int expMag;
        int magTol;
        int acceptCycle;
    } ExpItem;

    localparam int VX    [NVEC] = '{1000, 0, -1000, 0, -2048, 0, 1000, -2048, 2047, -700};
    localparam int VY    [NVEC] = '{0, 1000, 0, -1000, -2048, 0, 1000, 0, -2048, 300};
    localparam int VANG  [NVEC] = '{0, 1024, 2048, 3072, 2560, 0, 512, 2048, 3584, 1784};
    localparam int VATOL [NVEC] = '{1, 2, 2, 2, 2, 0, 3, 2, 3, 3};
`ifdef GAIN_COMP_EN
    localparam int LAT         = 14;
    localparam int VMAG  [NVEC] = '{1000, 1000, 1000, 1000, 2896, 0, 1414, 2048, 2896, 762};
    localparam int VMTOL [NVEC] = '{4, 6, 6, 6, 6, 0, 6, 8, 6, 6};
`else
    localparam int LAT         = 13;
    localparam int VMAG  [NVEC] = '{1647, 1647, 1647, 1647, 4770, 0, 2329, 3373, 4768, 1254};
    localparam int VMTOL [NVEC] = '{4, 6, 6, 6, 8, 0, 8, 8, 8, 8};
`endif

    logic               clock = 1'b0;
    logic               resetn;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x_in;
    logic [WIDTH-1:0]   y_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   angle;
    logic [WIDTH:0]     mag;

    int     vectorsApplied = 0;
    int     miscompares    = 0;
    int     cycleCount     = 0;
    ExpItem sbQueue[$];

    cordic_vector_12b #(.WIDTH(WIDTH), .ITER(12)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle     (angle),
        .mag       (mag)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount++;

    // Angles are compared modulo a full turn so tolerances work across the 0/4095 seam.
    task automatic checkOutput(input string name, input int actual, input int expected,
                               input int tol, input bit wrap);
        int diff;
        logic signed [WIDTH-1:0] d12;
        diff = actual - expected;
        if (wrap) begin
            d12  = diff[WIDTH-1:0];
            diff = d12;
        end
        if (diff < 0) diff = -diff;
        vectorsApplied++;
        if (diff > tol) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d (+/-%0d)", name, actual, expected, tol);
        end
    endtask

    // Called on a negedge; returns on the negedge after the acceptance edge.
    task automatic applyStimulus(input int xv, input int yv, input int expAngle, input int angTol,
                                 input int expMag, input int magTol, input bit track);
        int waitCycles = 0;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clock);
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("inReadyTimeout", 0, 1, 0, 1'b0);
            return;
        end
        x_in     = xv[WIDTH-1:0];
        y_in     = yv[WIDTH-1:0];
        in_valid = 1'b1;
        if (track) sbQueue.push_back('{expAngle, angTol, expMag, magTol, cycleCount});
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drainScoreboard();
        int n = 0;
        while ((sbQueue.size() != 0 || out_valid) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (sbQueue.size() != 0) begin
            checkOutput("resultTimeout", 0, 1, 0, 1'b0);
            sbQueue.delete();
        end
    endtask

    initial begin
        ExpItem item;
        bit prevValid = 1'b0;
        forever begin
            @(negedge clock);
            if (resetn && out_valid && !prevValid) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedResult", 1, 0, 0, 1'b0);
                end else begin
                    item = sbQueue.pop_front();
                    checkOutput("angle", int'(angle), item.expAngle, item.angTol, 1'b1);
                    checkOutput("mag", int'(mag), item.expMag, item.magTol, 1'b0);
                    checkOutput("latency", cycleCount - item.acceptCycle - 1, LAT, 0, 1'b0);
                end
            end
            prevValid = (out_valid === 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit sawValid;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;
        repeat (3) @(negedge clock);
        checkOutput("resetInReady", int'(in_ready), 0, 0, 1'b0);
        checkOutput("resetOutValid", int'(out_valid), 0, 0, 1'b0);
        checkOutput("resetAngle", int'(angle), 0, 0, 1'b0);
        checkOutput("resetMag", int'(mag), 0, 0, 1'b0);
        resetn = 1'b1;
        @(negedge clock);

        for (int v = 0; v < NVEC; v++) begin
            applyStimulus(VX[v], VY[v], VANG[v], VATOL[v], VMAG[v], VMTOL[v], 1'b1);
            drainScoreboard();
        end

        // Consumer stalls for five cycles while the result is presented.
        out_ready = 1'b0;
        applyStimulus(VX[0], VY[0], VANG[0], VATOL[0], VMAG[0], VMTOL[0], 1'b1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput("holdOutValid", int'(out_valid), 1, 0, 1'b0);
            checkOutput("holdInReady", int'(in_ready), 0, 0, 1'b0);
            checkOutput("holdAngle", int'(angle), VANG[0], VATOL[0], 1'b1);
            checkOutput("holdMag", int'(mag), VMAG[0], VMTOL[0], 1'b0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        checkOutput("releaseInReady", int'(in_ready), 1, 0, 1'b0);
        checkOutput("releaseOutValid", int'(out_valid), 0, 0, 1'b0);
        drainScoreboard();

        // Abort a computation while the engine is on micro-rotation 5.
        applyStimulus(1000, 1000, 0, 0, 0, 0, 1'b0);
        repeat (6) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        checkOutput("abortOutValid", int'(out_valid), 0, 0, 1'b0);
        checkOutput("abortInReady", int'(in_ready), 0, 0, 1'b0);
        checkOutput("abortAngle", int'(angle), 0, 0, 1'b0);
        checkOutput("abortMag", int'(mag), 0, 0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("postResetInReady", int'(in_ready), 1, 0, 1'b0);
        sawValid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) sawValid = 1'b1;
            @(negedge clock);
        end
        checkOutput("abandonedResult", int'(sawValid), 0, 0, 1'b0);

        applyStimulus(VX[1], VY[1], VANG[1], VATOL[1], VMAG[1], VMTOL[1], 1'b1);
        drainScoreboard();
        applyStimulus(VX[4], VY[4], VANG[4], VATOL[4], VMAG[4], VMTOL[4], 1'b1);
        drainScoreboard();

        checkOutput("scoreboardEmpty", sbQueue.size(), 0, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
